// File: rtl/rf_window_spill_ctrl.sv
// rf_window_spill_ctrl
// Spill/fill sequencer for the windowed register file. On a window overflow
// (RF_SPILL) or underflow (RF_FILL) it moves 2*N words between the register
// file bus and a single-port data memory over a req/gnt/rvalid handshake,
// freezes the pipeline for the whole transfer, and tracks the spill-stack
// pointer and the number of windows currently held in memory.
//
// Optional build macro: RF_WINCTRL_STATS_EN adds the saturating 16-bit
// SPILL_CNT / FILL_CNT outputs counting successful transfers.
module rf_window_spill_ctrl #(
  parameter int                NBITS      = 64,
  parameter int                N          = 3,
  parameter int                ADDR_W     = 32,
  parameter int                MAX_SPILL  = 8,
  parameter logic [ADDR_W-1:0] STACK_BASE = 32'h0000_F000
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              RF_SPILL,
  input  logic              RF_FILL,
  input  logic [NBITS-1:0]  RF_MEM_BUS,
  output logic [NBITS-1:0]  RF_MEM_BUSREAD,
  output logic              RF_XFER_ACK,
  output logic              STALL,
  output logic              DONE,
  output logic              ERR,
  output logic              MEM_REQ,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [NBITS-1:0]  MEM_WDATA,
  input  logic              MEM_GNT,
  input  logic              MEM_RVALID,
  input  logic [NBITS-1:0]  MEM_RDATA
`ifdef RF_WINCTRL_STATS_EN
  ,
  output logic [15:0]       SPILL_CNT,
  output logic [15:0]       FILL_CNT
`endif
);

  localparam int WORDS   = 2 * N;
  localparam int CNT_W   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int DEPTH_W = $clog2(MAX_SPILL + 1);

  localparam logic [ADDR_W-1:0]  WORD_B     = ADDR_W'(NBITS / 8);
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(WORDS - 1);
  localparam logic [DEPTH_W-1:0] DEPTH_FULL = DEPTH_W'(MAX_SPILL);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SPILL,
    S_FILL_REQ,
    S_FILL_WAIT,
    S_DONE
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [CNT_W-1:0]   cnt;
  logic [ADDR_W-1:0]  sp;
  logic [DEPTH_W-1:0] depth;
  logic               err;

  // Request qualification in IDLE: a spill always beats a simultaneous fill,
  // and a request that would overflow/underflow the stack is refused.
  logic spill_req;
  logic fill_req;
  logic spill_refused;
  logic fill_refused;

  // Handshake events that move one word or finish a window.
  logic spill_word;
  logic fill_word;
  logic spill_last;
  logic fill_last;
  logic fill_grant;

  assign spill_req     = (state == S_IDLE) && RF_SPILL;
  assign fill_req      = (state == S_IDLE) && !RF_SPILL && RF_FILL;
  assign spill_refused = spill_req && (depth == DEPTH_FULL);
  assign fill_refused  = fill_req && (depth == '0);

  assign spill_word = (state == S_SPILL) && MEM_GNT;
  assign fill_grant = (state == S_FILL_REQ) && MEM_GNT;
  assign fill_word  = (state == S_FILL_WAIT) && MEM_RVALID;
  assign spill_last = spill_word && (cnt == CNT_LAST);
  assign fill_last  = fill_word && (cnt == CNT_LAST);

  // State register; reset abandons any partial transfer.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: one word per grant on spill, request/response pairs on fill.
  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE: begin
        if (spill_req) begin
          next_state = spill_refused ? S_DONE : S_SPILL;
        end else if (fill_req) begin
          next_state = fill_refused ? S_DONE : S_FILL_REQ;
        end
      end
      S_SPILL: begin
        if (spill_last) begin
          next_state = S_DONE;
        end
      end
      S_FILL_REQ: begin
        if (MEM_GNT) begin
          next_state = S_FILL_WAIT;
        end
      end
      S_FILL_WAIT: begin
        if (MEM_RVALID) begin
          next_state = (cnt == CNT_LAST) ? S_DONE : S_FILL_REQ;
        end
      end
      S_DONE: begin
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // Output decode: memory request fields come straight from state and SP so
  // they stay stable while a request waits for its grant.
  always_comb begin
    MEM_REQ        = 1'b0;
    MEM_WE         = 1'b0;
    MEM_ADDR       = '0;
    MEM_WDATA      = '0;
    RF_MEM_BUSREAD = '0;
    RF_XFER_ACK    = 1'b0;
    DONE           = 1'b0;
    unique case (state)
      S_SPILL: begin
        MEM_REQ     = 1'b1;
        MEM_WE      = 1'b1;
        MEM_ADDR    = sp;
        MEM_WDATA   = RF_MEM_BUS;
        RF_XFER_ACK = MEM_GNT;
      end
      S_FILL_REQ: begin
        MEM_REQ  = 1'b1;
        MEM_ADDR = sp - WORD_B;
      end
      S_FILL_WAIT: begin
        if (MEM_RVALID) begin
          RF_MEM_BUSREAD = MEM_RDATA;
          RF_XFER_ACK    = 1'b1;
        end
      end
      S_DONE: begin
        DONE = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // The pipeline freezes as soon as a request appears, before the FSM leaves IDLE.
  assign STALL = (state != S_IDLE) || RF_SPILL || RF_FILL;
  assign ERR   = err;

  // Word counter: advances per transferred word, cleared at window end.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt <= '0;
    end else if (state == S_DONE) begin
      cnt <= '0;
    end else if (spill_word || fill_word) begin
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
    end
  end

  // Stack pointer: post-increment on spill writes, pre-decrement on fill reads.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sp <= STACK_BASE;
    end else if (spill_word) begin
      sp <= sp + WORD_B;
    end else if (fill_grant) begin
      sp <= sp - WORD_B;
    end
  end

  // Spilled-window depth: changes only when a whole window has moved.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      depth <= '0;
    end else if (spill_last) begin
      depth <= depth + DEPTH_W'(1);
    end else if (fill_last) begin
      depth <= depth - DEPTH_W'(1);
    end
  end

  // Sticky error flag, set on the same edge that sends a refused request to DONE.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      err <= 1'b0;
    end else if (spill_refused || fill_refused) begin
      err <= 1'b1;
    end
  end

`ifdef RF_WINCTRL_STATS_EN
  logic [15:0] spill_cnt;
  logic [15:0] fill_cnt;

  // Saturating counts of completed windows; refused requests are not counted.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      spill_cnt <= '0;
      fill_cnt  <= '0;
    end else begin
      if (spill_last && (spill_cnt != 16'hFFFF)) begin
        spill_cnt <= spill_cnt + 16'd1;
      end
      if (fill_last && (fill_cnt != 16'hFFFF)) begin
        fill_cnt <= fill_cnt + 16'd1;
      end
    end
  end

  assign SPILL_CNT = spill_cnt;
  assign FILL_CNT  = fill_cnt;
`endif

endmodule

// File: tb/tb_rf_window_spill_ctrl.sv
// tb_rf_window_spill_ctrl
// Self-checking bench: a stack-of-windows reference model predicts memory
// traffic, fill data and DONE/ERR; a monitor compares DUT activity against
// the predicted event queue. A simple memory (1-cycle read latency) and a
// register-file driver surround the DUT.
module tb_rf_window_spill_ctrl;

  localparam int NBITS     = 64;
  localparam int N         = 3;
  localparam int ADDR_W    = 32;
  localparam int MAX_SPILL = 8;
  localparam int WORDS     = 2 * N;
  localparam int WB        = NBITS / 8;
  localparam logic [31:0] BASE = 32'h0000_F000;

  logic              CLK = 1'b0;
  logic              RESET = 1'b0;
  logic              RF_SPILL = 1'b0;
  logic              RF_FILL = 1'b0;
  logic [NBITS-1:0]  RF_MEM_BUS = '0;
  logic [NBITS-1:0]  RF_MEM_BUSREAD;
  logic              RF_XFER_ACK;
  logic              STALL;
  logic              DONE;
  logic              ERR;
  logic              MEM_REQ;
  logic              MEM_WE;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [NBITS-1:0]  MEM_WDATA;
  logic              MEM_GNT = 1'b0;
  logic              MEM_RVALID = 1'b0;
  logic [NBITS-1:0]  MEM_RDATA = '0;
`ifdef RF_WINCTRL_STATS_EN
  logic [15:0]       SPILL_CNT;
  logic [15:0]       FILL_CNT;
`endif

  rf_window_spill_ctrl #(
    .NBITS(NBITS), .N(N), .ADDR_W(ADDR_W), .MAX_SPILL(MAX_SPILL), .STACK_BASE(BASE)
  ) dut (
    .CLK(CLK), .RESET(RESET), .RF_SPILL(RF_SPILL), .RF_FILL(RF_FILL),
    .RF_MEM_BUS(RF_MEM_BUS), .RF_MEM_BUSREAD(RF_MEM_BUSREAD), .RF_XFER_ACK(RF_XFER_ACK),
    .STALL(STALL), .DONE(DONE), .ERR(ERR), .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE),
    .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_GNT(MEM_GNT),
    .MEM_RVALID(MEM_RVALID), .MEM_RDATA(MEM_RDATA)
`ifdef RF_WINCTRL_STATS_EN
    , .SPILL_CNT(SPILL_CNT), .FILL_CNT(FILL_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  typedef enum logic [1:0] {EV_WR, EV_RD, EV_FDATA, EV_DONE} ev_kind_t;
  typedef struct packed {
    ev_kind_t    kind;
    logic [31:0] addr;
    logic [63:0] data;
    logic        err;
  } ev_t;

  ev_t sb[$];
  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: memory stack of spilled words plus pointer/depth/error.
  logic [31:0] ref_sp;
  int          ref_depth;
  logic        ref_err;
  logic [63:0] ref_stack[$];
  int          ref_spills;
  int          ref_fills;
  logic [63:0] spill_words[WORDS];

  // Environment controls and bench memory.
  int          gnt_mode = 0;
  logic [63:0] mem [logic [31:0]];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic resetModel();
    ref_sp = BASE;
    ref_depth = 0;
    ref_err = 1'b0;
    ref_stack.delete();
    ref_spills = 0;
    ref_fills = 0;
  endtask

  task automatic modelSpill();
    if (ref_depth == MAX_SPILL) begin
      ref_err = 1'b1;
      sb.push_back('{kind: EV_DONE, addr: 32'h0, data: 64'h0, err: 1'b1});
    end else begin
      for (int i = 0; i < WORDS; i++) begin
        sb.push_back('{kind: EV_WR, addr: ref_sp + 32'(WB * i), data: spill_words[i], err: 1'b0});
        ref_stack.push_back(spill_words[i]);
      end
      ref_sp = ref_sp + 32'(WB * WORDS);
      ref_depth++;
      ref_spills++;
      sb.push_back('{kind: EV_DONE, addr: 32'h0, data: 64'h0, err: ref_err});
    end
  endtask

  task automatic modelFill();
    if (ref_depth == 0) begin
      ref_err = 1'b1;
      sb.push_back('{kind: EV_DONE, addr: 32'h0, data: 64'h0, err: 1'b1});
    end else begin
      for (int i = 0; i < WORDS; i++) begin
        ref_sp = ref_sp - 32'(WB);
        sb.push_back('{kind: EV_RD, addr: ref_sp, data: 64'h0, err: 1'b0});
        sb.push_back('{kind: EV_FDATA, addr: 32'h0, data: ref_stack.pop_back(), err: 1'b0});
      end
      ref_depth--;
      ref_fills++;
      sb.push_back('{kind: EV_DONE, addr: 32'h0, data: 64'h0, err: ref_err});
    end
  endtask

  // Memory responder: grants per gnt_mode, stores writes, returns read data
  // one cycle after the grant, and occasionally injects a stray RVALID while
  // a spill is in progress.
  initial begin
    logic        hs, hs_we, was_wr;
    logic [31:0] hs_addr;
    logic [63:0] hs_wdata;
    int          hs_count, low_cnt;
    hs_count = 0;
    low_cnt = 0;
    forever begin
      @(negedge CLK);
      hs       = MEM_REQ && MEM_GNT;
      hs_we    = MEM_WE;
      hs_addr  = MEM_ADDR;
      hs_wdata = MEM_WDATA;
      was_wr   = MEM_REQ && MEM_WE;
      if (!MEM_REQ) begin
        hs_count = 0;
        low_cnt = 0;
      end else if (MEM_GNT) begin
        hs_count++;
      end else begin
        low_cnt++;
      end
      @(posedge CLK);
      #1;
      if (hs && hs_we) mem[hs_addr] = hs_wdata;
      if (hs && !hs_we) begin
        MEM_RVALID = 1'b1;
        MEM_RDATA  = mem.exists(hs_addr) ? mem[hs_addr] : 64'h0;
      end else if (gnt_mode == 1 && was_wr && $urandom_range(0, 3) == 0) begin
        MEM_RVALID = 1'b1;
        MEM_RDATA  = {$urandom, $urandom};
      end else begin
        MEM_RVALID = 1'b0;
        MEM_RDATA  = {$urandom, $urandom};
      end
      case (gnt_mode)
        1:       MEM_GNT = ($urandom_range(0, 3) != 0);
        2:       MEM_GNT = !(hs_count == 2 && low_cnt < 3);
        default: MEM_GNT = 1'b1;
      endcase
    end
  end

  // Monitor: compares every DUT output event against the predicted queue.
  initial begin
    ev_t e;
    forever begin
      @(negedge CLK);
      if (RESET) begin
        check("stall", 64'(STALL), 64'(RF_SPILL | RF_FILL));
        if (MEM_REQ && MEM_WE) check("spill_ack", 64'(RF_XFER_ACK), 64'(MEM_GNT));
        if (MEM_REQ && !MEM_WE) check("fill_req_ack", 64'(RF_XFER_ACK), 64'h0);
        if (MEM_REQ) begin
          if (sb.size() == 0) begin
            check("unexpected_mem_req", 64'(MEM_REQ), 64'h0);
          end else begin
            e = sb[0];
            check("mem_kind", 64'(MEM_WE), 64'(e.kind == EV_WR));
            check("mem_addr", 64'(MEM_ADDR), 64'(e.addr));
            if (MEM_WE) check("mem_wdata", MEM_WDATA, e.data);
            if (MEM_GNT) void'(sb.pop_front());
          end
        end else if (RF_XFER_ACK) begin
          if (sb.size() == 0) begin
            check("unexpected_fill_ack", 64'(RF_XFER_ACK), 64'h0);
          end else begin
            e = sb.pop_front();
            check("fill_event_kind", 64'(EV_FDATA), 64'(e.kind));
            check("fill_data", RF_MEM_BUSREAD, e.data);
          end
        end
        if (DONE) begin
          if (sb.size() == 0) begin
            check("unexpected_done", 64'(DONE), 64'h0);
          end else begin
            e = sb.pop_front();
            check("done_event_kind", 64'(EV_DONE), 64'(e.kind));
            check("err_at_done", 64'(ERR), 64'(e.err));
          end
        end
      end
    end
  end

  task automatic checkOutputsZero(input string tag);
    check({tag, "_mem_req"}, 64'(MEM_REQ), 64'h0);
    check({tag, "_mem_we"}, 64'(MEM_WE), 64'h0);
    check({tag, "_ack"}, 64'(RF_XFER_ACK), 64'h0);
    check({tag, "_done"}, 64'(DONE), 64'h0);
    check({tag, "_addr"}, 64'(MEM_ADDR), 64'h0);
    check({tag, "_wdata"}, MEM_WDATA, 64'h0);
    check({tag, "_busread"}, RF_MEM_BUSREAD, 64'h0);
    check({tag, "_stall"}, 64'(STALL), 64'h0);
    check({tag, "_err"}, 64'(ERR), 64'h0);
  endtask

  // Drives one RF request until DONE (or an optional mid-transfer reset).
  task automatic runXfer(input bit do_spill, input bit do_fill, input int abort_after,
                         output int done_cycle, output int acks);
    int  idx;
    bit  a, d, aborted;
    idx = 0;
    acks = 0;
    aborted = 1'b0;
    done_cycle = -1;
    RF_MEM_BUS = spill_words[0];
    RF_SPILL = do_spill;
    RF_FILL = do_fill;
    if (do_spill) modelSpill();
    else modelFill();
    for (int k = 0; k < 300; k++) begin
      @(negedge CLK);
      a = RF_XFER_ACK;
      d = DONE;
      @(posedge CLK);
      #1;
      if (a) begin
        acks++;
        idx++;
        if (idx < WORDS) RF_MEM_BUS = spill_words[idx];
      end
      if (d) begin
        done_cycle = k;
        RF_SPILL = 1'b0;
        RF_FILL = 1'b0;
        break;
      end
      if (abort_after > 0 && acks == abort_after) begin
        RESET = 1'b0;
        RF_SPILL = 1'b0;
        RF_FILL = 1'b0;
        #1;
        checkOutputsZero("mid_reset");
        sb.delete();
        resetModel();
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b1;
        aborted = 1'b1;
        break;
      end
    end
    if (!aborted) begin
      if (done_cycle < 0) begin
        n_cmp++;
        n_fail++;
        $display("[TB] FAIL xfer_timeout: no DONE within 300 cycles, DONE required");
        RF_SPILL = 1'b0;
        RF_FILL = 1'b0;
        sb.delete();
      end
      check("scoreboard_drained", 64'(sb.size()), 64'h0);
    end
  endtask

  task automatic randomWords();
    for (int i = 0; i < WORDS; i++) spill_words[i] = {$urandom, $urandom};
  endtask

  // Main stimulus sequence.
  initial begin
    int dc, acks, op;
    resetModel();
    gnt_mode = 0;
    repeat (3) @(posedge CLK);
    #1;
    checkOutputsZero("reset");
    RESET = 1'b1;
    @(posedge CLK);
    #1;

    for (int i = 0; i < WORDS; i++) spill_words[i] = 64'(i);
    runXfer(1'b1, 1'b0, 0, dc, acks);
    check("spill_done_cycle", 64'(dc), 64'd7);
    check("spill_ack_count", 64'(acks), 64'd6);

    runXfer(1'b0, 1'b1, 0, dc, acks);
    check("fill_done_cycle", 64'(dc), 64'd13);
    check("fill_ack_count", 64'(acks), 64'd6);

    runXfer(1'b0, 1'b1, 0, dc, acks);
    check("underflow_done_cycle", 64'(dc), 64'd1);
    check("underflow_err", 64'(ERR), 64'h1);

    gnt_mode = 2;
    randomWords();
    runXfer(1'b1, 1'b0, 0, dc, acks);
    check("held_gnt_done_cycle", 64'(dc), 64'd10);

    gnt_mode = 0;
    randomWords();
    runXfer(1'b1, 1'b1, 0, dc, acks);
    check("both_req_done_cycle", 64'(dc), 64'd7);

    gnt_mode = 1;
    for (int t = 0; t < 30; t++) begin
      randomWords();
      op = $urandom_range(0, 2);
      runXfer(op != 1, op != 0, 0, dc, acks);
    end

    gnt_mode = 0;
    while (ref_depth < MAX_SPILL) begin
      randomWords();
      runXfer(1'b1, 1'b0, 0, dc, acks);
    end
    randomWords();
    runXfer(1'b1, 1'b0, 0, dc, acks);
    check("overflow_done_cycle", 64'(dc), 64'd1);
    check("overflow_acks", 64'(acks), 64'd0);

`ifdef RF_WINCTRL_STATS_EN
    check("spill_cnt", 64'(SPILL_CNT), 64'(ref_spills));
    check("fill_cnt", 64'(FILL_CNT), 64'(ref_fills));
`endif

    runXfer(1'b0, 1'b1, 3, dc, acks);
    check("err_after_reset", 64'(ERR), 64'h0);

    randomWords();
    runXfer(1'b1, 1'b0, 0, dc, acks);
    check("post_reset_spill_cycle", 64'(dc), 64'd7);
    runXfer(1'b0, 1'b1, 0, dc, acks);
    check("post_reset_fill_cycle", 64'(dc), 64'd13);
    runXfer(1'b0, 1'b1, 0, dc, acks);
    check("post_reset_underflow_cycle", 64'(dc), 64'd1);

`ifdef RF_WINCTRL_STATS_EN
    check("spill_cnt_after_reset", 64'(SPILL_CNT), 64'd1);
    check("fill_cnt_after_reset", 64'(FILL_CNT), 64'd1);
`endif

    repeat (3) @(posedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete, completion required");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
